// File: rtl/cam_pkg.sv
// Shared definitions for the camera byte-protocol transmitter and its capture counterpart.
// Holds the FSM state encoding and the default frame timing.
package cam_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVbp,
    StLine,
    StHblank,
    StVfp
  } cam_state_e;

  localparam int unsigned DefAw      = 15;
  localparam int unsigned DefDw      = 12;
  localparam int unsigned DefHPix    = 160;
  localparam int unsigned DefVLines  = 120;
  localparam int unsigned DefVsCyc   = 8;
  localparam int unsigned DefVbpCyc  = 8;
  localparam int unsigned DefHbCyc   = 4;
  localparam int unsigned DefVfpCyc  = 8;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/cam_frame_tx.sv
// Streams an RGB444 frame buffer out as a camera byte stream (vsync/href/8-bit data),
// two bytes per pixel, with a one-cycle-latency frame-buffer read interface.
module cam_frame_tx
  import cam_pkg::*;
#(
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned H_PIX   = DefHPix,
  parameter int unsigned V_LINES = DefVLines,
  parameter int unsigned VS_CYC  = DefVsCyc,
  parameter int unsigned VBP_CYC = DefVbpCyc,
  parameter int unsigned HB_CYC  = DefHbCyc,
  parameter int unsigned VFP_CYC = DefVfpCyc
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] MEM_data_out,
  output logic          MEM_rd,
  output logic [AW-1:0] MEM_addr_out,
  output logic [7:0]    CAM_px_data,
  output logic          CAM_vsync,
  output logic          CAM_href,
  output logic          frame_done
);

  localparam int unsigned LineBytes = 2 * H_PIX;
  localparam int unsigned NumPix    = H_PIX * V_LINES;
  localparam int unsigned MaxA      = (VS_CYC > VBP_CYC) ? VS_CYC : VBP_CYC;
  localparam int unsigned MaxB      = (HB_CYC > VFP_CYC) ? HB_CYC : VFP_CYC;
  localparam int unsigned MaxCyc    = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned BW        = cnt_w(LineBytes);
  localparam int unsigned LW        = cnt_w(V_LINES);
  localparam int unsigned TW        = cnt_w(MaxCyc);

  localparam logic [BW-1:0] LastByte = BW'(LineBytes - 1);
  localparam logic [LW-1:0] LastLine = LW'(V_LINES - 1);
  localparam logic [AW-1:0] LastAddr = AW'(NumPix - 1);

  cam_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    pix_lo_q;
  logic          t_last;

  always_ff @(posedge CAM_pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      byte_q   <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      pix_lo_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      // Byte 1 comes straight from the buffer; only byte 2 needs the held copy.
      if (state_q == StLine && !byte_q[0]) pix_lo_q <= MEM_data_out[7:0];
    end
  end

  always_comb begin
    t_last = 1'b0;
    case (state_q)
      StVsync:  t_last = (timer_q == TW'(VS_CYC - 1));
      StVbp:    t_last = (timer_q == TW'(VBP_CYC - 1));
      StHblank: t_last = (timer_q == TW'(HB_CYC - 1));
      StVfp:    t_last = (timer_q == TW'(VFP_CYC - 1));
      default:  t_last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    byte_d  = byte_q;
    line_d  = line_q;
    case (state_q)
      StIdle: begin
        byte_d = '0;
        line_d = '0;
        if (en) state_d = StVsync;
      end
      StVsync: begin
        line_d = '0;
        if (t_last) state_d = StVbp;
        else        timer_d = timer_q + 1'b1;
      end
      StVbp, StHblank: begin
        if (t_last) begin
          state_d = StLine;
          byte_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StLine: begin
        byte_d = byte_q + 1'b1;
        if (byte_q == LastByte) begin
          byte_d = '0;
          if (line_q == LastLine) begin
            state_d = StVfp;
          end else begin
            state_d = StHblank;
            line_d  = line_q + 1'b1;
          end
        end
      end
      StVfp: begin
        if (t_last) begin
          line_d  = '0;
          state_d = en ? StVsync : StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    MEM_rd      = 1'b0;
    CAM_vsync   = 1'b0;
    CAM_href    = 1'b0;
    CAM_px_data = '0;
    frame_done  = 1'b0;
    case (state_q)
      StVsync: CAM_vsync = 1'b1;
      StVbp, StHblank: MEM_rd = t_last;
      StLine: begin
        CAM_href = 1'b1;
        // Next pixel is fetched on byte 2 so it lands exactly for the following byte 1.
        MEM_rd   = byte_q[0] && (byte_q != LastByte);
        if (!byte_q[0]) CAM_px_data = {4'h0, MEM_data_out[11:8]};
        else            CAM_px_data = pix_lo_q;
      end
      StVfp: frame_done = t_last;
      default: ;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == StIdle || state_q == StVsync) addr_d = '0;
    else if (MEM_rd) addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
  end

  assign MEM_addr_out = addr_q;

endmodule

// File: tb/tb_cam_frame_tx.sv
// Self-checking bench for cam_frame_tx on a 4x2 frame with a registered frame-buffer model.
// A per-frame expected trace is built from the protocol rules and compared every cycle.
module tb_cam_frame_tx;
  import cam_pkg::*;

  localparam int unsigned H     = 4;
  localparam int unsigned V     = 2;
  localparam int unsigned VS    = 8;
  localparam int unsigned VBP   = 8;
  localparam int unsigned HB    = 4;
  localparam int unsigned VFP   = 8;
  localparam int unsigned FLEN  = VS + VBP + V * 2 * H + (V - 1) * HB + VFP;

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic [7:0]  px;
    logic        rd;
    logic [14:0] addr;
    logic        done;
  } exp_t;

  logic        CAM_pclk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [11:0] MEM_data_out = '0;
  logic        MEM_rd;
  logic [14:0] MEM_addr_out;
  logic [7:0]  CAM_px_data;
  logic        CAM_vsync;
  logic        CAM_href;
  logic        frame_done;

  cam_frame_tx #(
    .AW(15), .DW(12), .H_PIX(H), .V_LINES(V),
    .VS_CYC(VS), .VBP_CYC(VBP), .HB_CYC(HB), .VFP_CYC(VFP)
  ) dut (
    .CAM_pclk    (CAM_pclk),
    .rst         (rst),
    .en          (en),
    .MEM_data_out(MEM_data_out),
    .MEM_rd      (MEM_rd),
    .MEM_addr_out(MEM_addr_out),
    .CAM_px_data (CAM_px_data),
    .CAM_vsync   (CAM_vsync),
    .CAM_href    (CAM_href),
    .frame_done  (frame_done)
  );

  always #5 CAM_pclk = ~CAM_pclk;

  // Frame buffer: memory[a] = a + 12'h100, data valid the cycle after the read.
  always @(posedge CAM_pclk) if (MEM_rd) MEM_data_out <= 12'h100 + 12'(MEM_addr_out);

  int checks = 0;
  int passed = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endfunction

  exp_t exp_a [FLEN];

  function automatic void build_model();
    int i = 0;
    logic [11:0] pix;
    for (int k = 0; k < FLEN; k++) exp_a[k] = '0;
    for (int k = 0; k < VS; k++) begin exp_a[i].vs = 1'b1; i++; end
    for (int k = 0; k < VBP; k++) begin
      if (k == VBP - 1) exp_a[i].rd = 1'b1;
      i++;
    end
    for (int l = 0; l < V; l++) begin
      for (int b = 0; b < 2 * H; b++) begin
        pix = 12'h100 + 12'(l * H + b / 2);
        exp_a[i].hr = 1'b1;
        exp_a[i].px = (b % 2 == 0) ? {4'h0, pix[11:8]} : pix[7:0];
        if (b % 2 == 1 && b / 2 < H - 1) begin
          exp_a[i].rd   = 1'b1;
          exp_a[i].addr = 15'(l * H + b / 2 + 1);
        end
        i++;
      end
      if (l < V - 1) begin
        for (int k = 0; k < HB; k++) begin
          if (k == HB - 1) begin
            exp_a[i].rd   = 1'b1;
            exp_a[i].addr = 15'((l + 1) * H);
          end
          i++;
        end
      end else begin
        for (int k = 0; k < VFP; k++) begin
          if (k == VFP - 1) exp_a[i].done = 1'b1;
          i++;
        end
      end
    end
  endfunction

  // Model position: idle, or index into the expected frame trace.
  logic m_active = 1'b0;
  int   m_idx = 0;

  always @(posedge CAM_pclk) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_idx    <= 0;
    end else if (!m_active) begin
      if (en) begin m_active <= 1'b1; m_idx <= 0; end
    end else if (m_idx == FLEN - 1) begin
      m_active <= en;
      m_idx    <= 0;
    end else begin
      m_idx <= m_idx + 1;
    end
  end

  always @(negedge CAM_pclk) begin
    exp_t e;
    exp_t a;
    e = (!rst || !m_active) ? '0 : exp_a[m_idx];
    a.vs   = CAM_vsync;
    a.hr   = CAM_href;
    a.px   = CAM_px_data;
    a.rd   = MEM_rd;
    a.addr = (e.rd || !rst || !m_active) ? MEM_addr_out : 15'h0;
    a.done = frame_done;
    check($sformatf("cycle act=%0d idx=%0d", m_active, m_idx), 32'(a), 32'(e));
  end

  // href run lengths must always be a full line, except when cut by reset.
  int run = 0;
  always @(negedge CAM_pclk) begin
    if (!rst) run <= 0;
    else if (CAM_href) run <= run + 1;
    else if (run != 0) begin
      check("href_run", 32'(run), 32'(2 * H));
      run <= 0;
    end
  end

  int cyc = 0;
  int done_cnt = 0;
  int last_done = 0;
  int prev_done = 0;
  always @(posedge CAM_pclk) cyc <= cyc + 1;
  always @(negedge CAM_pclk) if (rst && frame_done) begin
    prev_done <= last_done;
    last_done <= cyc;
    done_cnt  <= done_cnt + 1;
  end

  task automatic tick();
    @(negedge CAM_pclk);
    #1;
  endtask

  task automatic wait_href(input int budget);
    int g = 0;
    while (!CAM_href && g < budget) begin tick(); g++; end
    check("href_seen", 32'(CAM_href), 32'd1);
  endtask

  logic [7:0] got_b [8];
  logic [7:0] lit_b [8];
  int d0;
  int g;
  int n;

  initial begin
    build_model();
    lit_b = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03};
    for (int k = 0; k < 8; k++) check($sformatf("model_byte%0d", k), 32'(exp_a[VS+VBP+k].px),
                                      32'(lit_b[k]));
    check("model_len", 32'(FLEN), 32'd44);

    repeat (3) @(posedge CAM_pclk);
    #1;
    check("rst_outs", {26'h0, CAM_vsync, CAM_href, MEM_rd, frame_done, 2'b0}, 32'h0);
    check("rst_data", {9'h0, CAM_px_data, MEM_addr_out}, 32'h0);

    // Continuous frames with en held.
    @(posedge CAM_pclk); #1;
    rst = 1'b1;
    en  = 1'b1;
    wait_href(100);
    for (int k = 0; k < 8; k++) begin got_b[k] = CAM_px_data; tick(); end
    for (int k = 0; k < 8; k++) check($sformatf("line0_byte%0d", k), 32'(got_b[k]),
                                      32'(lit_b[k]));
    g = 0;
    while (done_cnt < 2 && g < 300) begin tick(); g++; end
    check("done_twice", 32'(done_cnt), 32'd2);
    check("done_period", 32'(last_done - prev_done), 32'd44);

    // Drop en during line 1 of the next frame; it must still complete.
    d0 = done_cnt;
    repeat (VS + VBP + 2 * H + HB + 2) @(posedge CAM_pclk);
    #1;
    en = 1'b0;
    repeat (100) tick();
    check("drop_done_once", 32'(done_cnt - d0), 32'd1);
    check("drop_idle", {22'h0, CAM_vsync, CAM_href, MEM_rd, CAM_px_data}, 32'h0);

    // Single-cycle en pulse in idle gives exactly one frame.
    d0 = done_cnt;
    @(posedge CAM_pclk); #1;
    en = 1'b1;
    @(posedge CAM_pclk); #1;
    en = 1'b0;
    repeat (120) tick();
    check("pulse_done_once", 32'(done_cnt - d0), 32'd1);

    // Reset mid-line: href must drop at once, restart is a full vsync from address 0.
    @(posedge CAM_pclk); #1;
    en = 1'b1;
    wait_href(100);
    repeat (5) @(posedge CAM_pclk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_href_drop", {23'h0, CAM_href, CAM_px_data}, 32'h0);
    repeat (3) @(posedge CAM_pclk);
    #1;
    rst = 1'b1;
    g = 0;
    while (!CAM_vsync && g < 20) begin tick(); g++; end
    n = 0;
    while (CAM_vsync && n < 50) begin n++; tick(); end
    check("vsync_len", 32'(n), 32'(VS));
    g = 0;
    while (!MEM_rd && g < 50) begin tick(); g++; end
    check("first_rd", 32'(MEM_rd), 32'd1);
    check("first_addr", 32'(MEM_addr_out), 32'd0);
    en = 1'b0;
    repeat (80) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
